// File: rtl/rglib_rotate_pkg.sv
// Shared types and sizing helpers for the rglib rotate stages.
// Used by the issue stage, the credit counter and the rotator bench.
package rglib_rotate_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_POW_GRANULARITY = 0;

    function automatic int stage_num(input int data_width, input int pow_granularity);
        return $clog2(data_width) - pow_granularity;
    endfunction

    function automatic int credit_cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int DEFAULT_STAGE_NUM = stage_num(DEFAULT_DATA_WIDTH, DEFAULT_POW_GRANULARITY);

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic [DEFAULT_STAGE_NUM-1:0]  rotate_val;
    } issue_beat_t;

endpackage

// File: rtl/rglib_credit_cnt.sv
// Saturating downstream-credit counter with a sticky overflow flag.
// avail is registered so consumers see no combinational path from take/give.
module rglib_credit_cnt
    import rglib_rotate_pkg::*;
#(
    parameter  int CREDITS = 4,
    localparam int CW      = credit_cnt_width(CREDITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] cnt,
    output logic          avail,
    output logic          overflow
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          avail_r;
    logic          overflow_r;
    logic          ovf_set_s;

    // Next credit count; a return while already full is flagged, never counted.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_set_s = 1'b0;
        case ({take, give})
            2'b10: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            2'b01: begin
                if (cnt_r == CW'(CREDITS)) begin
                    ovf_set_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Counter, availability and sticky overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= CW'(CREDITS);
            avail_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            avail_r    <= (cnt_nxt_s != {CW{1'b0}});
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    assign cnt      = cnt_r;
    assign avail    = avail_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/rglib_rotate_feed.sv
// Issue stage for rglib_rotate: keeps the running rotate offset and gates
// issue on downstream credits, since the rotator cannot apply backpressure.
module rglib_rotate_feed
    import rglib_rotate_pkg::*;
#(
    parameter  int DATA_WIDTH       = 32,
    parameter  int POW_GRANULARITY  = 0,
    parameter  int ROTATE_STAGE_NUM = stage_num(DATA_WIDTH, POW_GRANULARITY),
    parameter  int CREDITS          = 4,
    localparam int CW               = credit_cnt_width(CREDITS)
) (
    input  logic                        clk,
    input  logic                        kill_n,
    input  logic                        clear,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic [ROTATE_STAGE_NUM-1:0] s_step,
    input  logic                        s_restart,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out,
    output logic [ROTATE_STAGE_NUM-1:0] out_rotate_val,
    input  logic                        credit_return,
    output logic [CW-1:0]               credit_cnt,
    output logic                        credit_err
);

    logic [ROTATE_STAGE_NUM-1:0] offset_r;
    logic [ROTATE_STAGE_NUM-1:0] offset_nxt_s;
    logic                        out_valid_r;
    logic [DATA_WIDTH-1:0]       out_r;
    logic [ROTATE_STAGE_NUM-1:0] out_rot_r;
    logic                        avail_s;
    logic                        accept_s;

    rglib_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk      (clk),
        .rst_n    (kill_n),
        .take     (accept_s),
        .give     (credit_return),
        .cnt      (credit_cnt),
        .avail    (avail_s),
        .overflow (credit_err)
    );

    assign s_ready  = avail_s & ~clear;
    assign accept_s = s_valid & s_ready;

    // Offset for the current beat; the add wraps modulo the granule count.
    always_comb begin
        offset_nxt_s = offset_r;
        if (s_restart) begin
            offset_nxt_s = s_step;
        end else begin
            offset_nxt_s = offset_r + s_step;
        end
    end

    // Running offset; clear wins and blocks accept through s_ready.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            offset_r <= {ROTATE_STAGE_NUM{1'b0}};
        end else if (clear) begin
            offset_r <= {ROTATE_STAGE_NUM{1'b0}};
        end else if (accept_s) begin
            offset_r <= offset_nxt_s;
        end else begin
            offset_r <= offset_r;
        end
    end

    // Issue register towards the rotator; data and rotate value hold when idle.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            out_valid_r <= 1'b0;
            out_r       <= {DATA_WIDTH{1'b0}};
            out_rot_r   <= {ROTATE_STAGE_NUM{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_r       <= s_data;
            out_rot_r   <= offset_nxt_s;
        end else begin
            out_valid_r <= 1'b0;
            out_r       <= out_r;
            out_rot_r   <= out_rot_r;
        end
    end

    assign out_valid      = out_valid_r;
    assign out            = out_r;
    assign out_rotate_val = out_rot_r;

endmodule

// File: tb/tb_rglib_rotate_feed.sv
// Scoreboard bench for rglib_rotate_feed: driver predicts each issued beat,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_rglib_rotate_feed;

    localparam int DW   = 32;
    localparam int RSN  = 5;
    localparam int CRED = 4;

    logic           clk = 1'b0;
    logic           kill_n = 1'b0;
    logic           clear = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic [RSN-1:0] s_step = '0;
    logic           s_restart = 1'b0;
    logic           out_valid;
    logic [DW-1:0]  out;
    logic [RSN-1:0] out_rotate_val;
    logic           credit_return = 1'b0;
    logic [2:0]     credit_cnt;
    logic           credit_err;

    rglib_rotate_feed #(
        .DATA_WIDTH      (DW),
        .POW_GRANULARITY (0),
        .CREDITS         (CRED)
    ) dut (
        .clk            (clk),
        .kill_n         (kill_n),
        .clear          (clear),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_step         (s_step),
        .s_restart      (s_restart),
        .out_valid      (out_valid),
        .out            (out),
        .out_rotate_val (out_rotate_val),
        .credit_return  (credit_return),
        .credit_cnt     (credit_cnt),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_beat;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    // Reference state: offset as an integer modulo 32, credits as a count.
    int m_off = 0;
    int m_cred = CRED;
    bit m_err = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_off = 0;
        m_cred = CRED;
        m_err = 1'b0;
        exp_q.delete();
        last_beat.d = '0;
        last_beat.r = 0;
    endtask

    // One clock of stimulus: check state, drive, check s_ready, predict.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input int st,
                       input bit rs, input bit cr, input bit cl);
        bit   acc;
        int   nxt;
        exp_t e;
        @(posedge clk);
        #1;
        chk("credit_cnt", credit_cnt, m_cred);
        chk("credit_err", credit_err, m_err);
        s_valid = v;
        s_data = d;
        s_step = RSN'(st);
        s_restart = rs;
        credit_return = cr;
        clear = cl;
        #1;
        chk("s_ready", s_ready, (m_cred != 0) && !cl);
        acc = v && (m_cred != 0) && !cl;
        if (acc) begin
            nxt = rs ? st : (m_off + st) % 32;
            e.d = d;
            e.r = nxt;
            exp_q.push_back(e);
            m_off = nxt;
        end
        if (cl) m_off = 0;
        if (acc && !cr) m_cred--;
        else if (cr && !acc) begin
            if (m_cred == CRED) m_err = 1'b1;
            else m_cred++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every presented beat must match the oldest prediction.
    always @(negedge clk) begin
        if (kill_n) begin
            if (out_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=out_valid expected=no_beat");
                end else begin
                    last_beat = exp_q.pop_front();
                    chk("out_data", out, last_beat.d);
                    chk("out_rotate_val", out_rotate_val, last_beat.r);
                end
            end else begin
                chk("hold_data", out, last_beat.d);
                chk("hold_rotate_val", out_rotate_val, last_beat.r);
            end
        end
    end

    initial begin
        int snap;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_rotate_val", out_rotate_val, 0);
        chk("rst_credit_cnt", credit_cnt, CRED);
        chk("rst_credit_err", credit_err, 0);
        @(negedge clk);
        kill_n = 1'b1;

        // Steps 1..4 with no returns: offsets 1,3,6,10 then stall.
        for (int i = 1; i <= 4; i++) cyc(1'b1, $urandom, i, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1, 1'b0, 1'b0, 1'b0);

        // Single return at zero credits admits exactly one beat.
        cyc(1'b1, $urandom, 5, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);

        // Wrap and restart, then a zero step.
        cyc(1'b1, $urandom, 30, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 5, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 7, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Accept and return together for 20 cycles.
        snap = pulses;
        for (int i = 0; i < 20; i++)
            cyc(1'b1, $urandom, int'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("pulses_20", pulses - snap, 20);

        // Return while full sets the sticky error.
        cyc(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("credit_err_sticky", credit_err, 1);

        // Clear at offset 9 blocks the beat and zeroes the offset.
        cyc(1'b1, $urandom, 9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, $urandom, 2, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream while a beat is presented.
        cyc(1'b1, $urandom, 4, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_kill_out_valid", out_valid, 1);
        kill_n = 1'b0;
        s_valid = 1'b0;
        credit_return = 1'b0;
        clear = 1'b0;
        #1;
        chk("kill_out_valid", out_valid, 0);
        chk("kill_credit_cnt", credit_cnt, CRED);
        chk("kill_credit_err", credit_err, 0);
        model_reset();
        @(negedge clk);
        kill_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom, int'($urandom_range(0, 31)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0));
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
